// File: rtl/alert_handler_reg_pkg.sv
// Shared sizing constants and escalation FSM state encoding for the alert
// handler class controller.
package alert_handler_reg_pkg;

    localparam int unsigned N_ESC_SEV = 4;
    localparam int unsigned N_PHASES  = 4;
    localparam int unsigned PHASE_DW  = 2;
    localparam int unsigned AccuCntDw = 16;
    localparam int unsigned EscCntDw  = 32;

    typedef enum logic [2:0] {
        st_idle     = 3'b000,
        st_timeout  = 3'b001,
        st_terminal = 3'b011,
        st_phase0   = 3'b100,
        st_phase1   = 3'b101,
        st_phase2   = 3'b110,
        st_phase3   = 3'b111
    } cstate_e;

    // True once escalation has started (any phase or the terminal state).
    function automatic logic is_esc_state(input cstate_e st);
        return st[2] | (st == st_terminal);
    endfunction

endpackage

// File: rtl/alert_handler_accu.sv
// Saturating alert accumulator with a combinational threshold-crossing pulse
// evaluated against the pre-increment count.
module alert_handler_accu #(
    parameter int unsigned AccuCntDw = alert_handler_reg_pkg::AccuCntDw
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 hit_i,
    input  logic [AccuCntDw-1:0] accu_thresh_i,
    output logic [AccuCntDw-1:0] accu_cnt_o,
    output logic                 accu_trig_o
);

    logic [AccuCntDw-1:0] accu_cnt_r;

    // Accumulator: clear wins, otherwise count hits up to all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            accu_cnt_r <= {AccuCntDw{1'b0}};
        end else if (clr_i) begin
            accu_cnt_r <= {AccuCntDw{1'b0}};
        end else if (hit_i && (accu_cnt_r != {AccuCntDw{1'b1}})) begin
            accu_cnt_r <= accu_cnt_r + {{(AccuCntDw-1){1'b0}}, 1'b1};
        end else begin
            accu_cnt_r <= accu_cnt_r;
        end
    end

    // rst_ni gating keeps the pulse quiet while reset is held.
    assign accu_trig_o = rst_ni & hit_i & (accu_cnt_r >= accu_thresh_i);
    assign accu_cnt_o  = accu_cnt_r;

endmodule

// File: rtl/alert_handler_class_ctrl.sv
// Alert class controller: accumulator, interrupt timeout and phased escalation.
// Optional macro ALERT_HANDLER_CLASS_CLR_LOCK_EN adds clr_lock_i to lock clear.
module alert_handler_class_ctrl
    import alert_handler_reg_pkg::*;
#(
    parameter int unsigned AccuCntDw = alert_handler_reg_pkg::AccuCntDw,
    parameter int unsigned EscCntDw  = alert_handler_reg_pkg::EscCntDw,
    parameter int unsigned N_ESC_SEV = alert_handler_reg_pkg::N_ESC_SEV,
    parameter int unsigned N_PHASES  = alert_handler_reg_pkg::N_PHASES,
    parameter int unsigned PHASE_DW  = alert_handler_reg_pkg::PHASE_DW
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    input  logic                          class_trig_i,
    input  logic                          clr_i,
`ifdef ALERT_HANDLER_CLASS_CLR_LOCK_EN
    input  logic                          clr_lock_i,
`endif
    input  logic [AccuCntDw-1:0]          accu_thresh_i,
    input  logic [EscCntDw-1:0]           timeout_cyc_i,
    input  logic [N_PHASES*EscCntDw-1:0]  phase_cyc_i,
    input  logic [N_ESC_SEV-1:0]          esc_en_i,
    input  logic [N_ESC_SEV*PHASE_DW-1:0] esc_map_i,
    output logic [AccuCntDw-1:0]          accu_cnt_o,
    output logic                          accu_trig_o,
    output logic [N_ESC_SEV-1:0]          esc_sig_o,
    output logic [2:0]                    esc_state_o,
    output logic [EscCntDw-1:0]           esc_cnt_o
);

    localparam logic [EscCntDw-1:0] ESC_ZERO = {EscCntDw{1'b0}};
    localparam logic [EscCntDw-1:0] ESC_ONE  = {{(EscCntDw-1){1'b0}}, 1'b1};
    localparam logic [EscCntDw-1:0] ESC_MAX  = {EscCntDw{1'b1}};

    cstate_e               state_r, state_s;
    logic [EscCntDw-1:0]   esc_cnt_r, esc_cnt_s;
    logic                  hit_s, clr_s, accu_trig_s;
    logic [PHASE_DW-1:0]   phase_idx_s;
    logic [EscCntDw-1:0]   phase_cyc_s [N_PHASES];
    logic [EscCntDw-1:0]   phase_last_s, cnt_inc_s;
    logic                  phase_done_s, tmo_done_s;
    logic [N_ESC_SEV-1:0]  esc_sig_s;

    assign hit_s = en_i & class_trig_i;

`ifdef ALERT_HANDLER_CLASS_CLR_LOCK_EN
    assign clr_s = clr_i & ~(clr_lock_i & is_esc_state(state_r));
`else
    assign clr_s = clr_i;
`endif

    alert_handler_accu #(
        .AccuCntDw (AccuCntDw)
    ) u_accu (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clr_i         (clr_s),
        .hit_i         (hit_s),
        .accu_thresh_i (accu_thresh_i),
        .accu_cnt_o    (accu_cnt_o),
        .accu_trig_o   (accu_trig_s)
    );

    for (genvar k = 0; k < N_PHASES; k++) begin : g_phase_cyc
        assign phase_cyc_s[k] = phase_cyc_i[k*EscCntDw +: EscCntDw];
    end

    // Phase index is the low bits of a phase state; a zero duration still lasts one cycle.
    assign phase_idx_s  = state_r[PHASE_DW-1:0];
    assign phase_last_s = (phase_cyc_s[phase_idx_s] == ESC_ZERO) ? ESC_ZERO
                                                                 : (phase_cyc_s[phase_idx_s] - ESC_ONE);
    assign phase_done_s = (esc_cnt_r >= phase_last_s);
    assign tmo_done_s   = (esc_cnt_r >= (timeout_cyc_i - ESC_ONE));
    assign cnt_inc_s    = (esc_cnt_r == ESC_MAX) ? esc_cnt_r : (esc_cnt_r + ESC_ONE);

    // Next-state and counter logic; clear overrides every other event.
    always_comb begin
        state_s   = state_r;
        esc_cnt_s = esc_cnt_r;
        if (clr_s) begin
            state_s   = st_idle;
            esc_cnt_s = ESC_ZERO;
        end else begin
            case (state_r)
                st_idle: begin
                    esc_cnt_s = ESC_ZERO;
                    if (accu_trig_s) begin
                        state_s = st_phase0;
                    end else if (hit_s && (timeout_cyc_i != ESC_ZERO)) begin
                        state_s = st_timeout;
                    end else begin
                        state_s = st_idle;
                    end
                end
                st_timeout: begin
                    if (accu_trig_s || tmo_done_s) begin
                        state_s   = st_phase0;
                        esc_cnt_s = ESC_ZERO;
                    end else begin
                        esc_cnt_s = cnt_inc_s;
                    end
                end
                st_phase0, st_phase1, st_phase2: begin
                    if (phase_done_s) begin
                        state_s   = cstate_e'(state_r + 3'd1);
                        esc_cnt_s = ESC_ZERO;
                    end else begin
                        esc_cnt_s = cnt_inc_s;
                    end
                end
                st_phase3: begin
                    if (phase_done_s) begin
                        state_s   = st_terminal;
                        esc_cnt_s = ESC_ZERO;
                    end else begin
                        esc_cnt_s = cnt_inc_s;
                    end
                end
                st_terminal: begin
                    state_s   = st_terminal;
                    esc_cnt_s = ESC_ZERO;
                end
                default: begin
                    state_s   = st_idle;
                    esc_cnt_s = ESC_ZERO;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= st_idle;
            esc_cnt_r <= ESC_ZERO;
        end else begin
            state_r   <= state_s;
            esc_cnt_r <= esc_cnt_s;
        end
    end

    // Severity s fires while the FSM sits in the phase mapped to it.
    always_comb begin
        esc_sig_s = {N_ESC_SEV{1'b0}};
        for (int s = 0; s < N_ESC_SEV; s++) begin
            esc_sig_s[s] = esc_en_i[s] & state_r[2] &
                           (esc_map_i[s*PHASE_DW +: PHASE_DW] == phase_idx_s);
        end
    end

    assign accu_trig_o = accu_trig_s;
    assign esc_sig_o   = esc_sig_s;
    assign esc_state_o = state_r;
    assign esc_cnt_o   = esc_cnt_r;

endmodule

// File: tb/tb_alert_handler_class_ctrl.sv
// Self-checking bench for alert_handler_class_ctrl: vector table, directed
// corner sequences and randomized traffic against a behavioural model.
module tb_alert_handler_class_ctrl;

    localparam int ACW = 5;
    localparam int ECW = 32;
    localparam int NS  = 4;
    localparam int NP  = 4;
    localparam int PDW = 2;
    localparam int ACCU_MAX = (1 << ACW) - 1;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              en_i = 1'b0, class_trig_i = 1'b0, clr_i = 1'b0;
    logic              clr_lock_i = 1'b0;
    logic [ACW-1:0]    accu_thresh_i = '0;
    logic [ECW-1:0]    timeout_cyc_i = '0;
    logic [NP*ECW-1:0] phase_cyc_i = '0;
    logic [NS-1:0]     esc_en_i = '0;
    logic [NS*PDW-1:0] esc_map_i = '0;
    logic [ACW-1:0]    accu_cnt_o;
    logic              accu_trig_o;
    logic [NS-1:0]     esc_sig_o;
    logic [2:0]        esc_state_o;
    logic [ECW-1:0]    esc_cnt_o;

    alert_handler_class_ctrl #(
        .AccuCntDw (ACW), .EscCntDw (ECW), .N_ESC_SEV (NS), .N_PHASES (NP), .PHASE_DW (PDW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .class_trig_i  (class_trig_i),
        .clr_i         (clr_i),
`ifdef ALERT_HANDLER_CLASS_CLR_LOCK_EN
        .clr_lock_i    (clr_lock_i),
`endif
        .accu_thresh_i (accu_thresh_i),
        .timeout_cyc_i (timeout_cyc_i),
        .phase_cyc_i   (phase_cyc_i),
        .esc_en_i      (esc_en_i),
        .esc_map_i     (esc_map_i),
        .accu_cnt_o    (accu_cnt_o),
        .accu_trig_o   (accu_trig_o),
        .esc_sig_o     (esc_sig_o),
        .esc_state_o   (esc_state_o),
        .esc_cnt_o     (esc_cnt_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: mode 0 idle, 1 timeout, 2..5 phase 0..3, 6 terminal.
    int     m_accu = 0;
    int     m_mode = 0;
    longint m_cnt  = 0;

    typedef struct {
        logic       en;
        logic       trig;
        logic       clr;
        int         accu;
        logic       trig_o;
        logic [2:0] st;
    } vec_t;
    vec_t vt[6];

    function automatic logic [2:0] mode_code(input int m);
        logic [2:0] codes [7];
        codes = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b011};
        return codes[m];
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic m_hit();
        return en_i & class_trig_i;
    endfunction

    task automatic model_check();
        logic [NS-1:0] esc;
        esc = '0;
        for (int s = 0; s < NS; s++)
            if (esc_en_i[s] && m_mode >= 2 && m_mode <= 5 && int'(esc_map_i[s*PDW +: PDW]) == m_mode - 2)
                esc[s] = 1'b1;
        chk("model_accu",  accu_cnt_o,  m_accu);
        chk("model_trig",  accu_trig_o, (m_hit() && m_accu >= int'(accu_thresh_i)) ? 1 : 0);
        chk("model_state", esc_state_o, mode_code(m_mode));
        chk("model_cnt",   esc_cnt_o,   m_cnt);
        chk("model_esc",   esc_sig_o,   esc);
    endtask

    task automatic model_step();
        logic       hit, trig, clr_eff;
        logic [ECW-1:0] lim;
        longint dur;
        hit  = m_hit();
        trig = hit && (m_accu >= int'(accu_thresh_i));
        clr_eff = clr_i;
`ifdef ALERT_HANDLER_CLASS_CLR_LOCK_EN
        if (clr_lock_i && m_mode >= 2) clr_eff = 1'b0;
`endif
        if (clr_eff) begin
            m_accu = 0; m_mode = 0; m_cnt = 0;
        end else begin
            if (hit && m_accu < ACCU_MAX) m_accu = m_accu + 1;
            if (m_mode == 0) begin
                if (trig) m_mode = 2;
                else if (hit && timeout_cyc_i != 0) m_mode = 1;
                m_cnt = 0;
            end else if (m_mode == 1) begin
                lim = timeout_cyc_i - 32'd1;
                if (trig || m_cnt >= longint'(lim)) begin m_mode = 2; m_cnt = 0; end
                else if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end else if (m_mode <= 5) begin
                dur = longint'(phase_cyc_i[(m_mode-2)*ECW +: ECW]);
                if (dur < 1) dur = 1;
                if (m_cnt + 1 >= dur) begin m_mode = m_mode + 1; m_cnt = 0; end
                else m_cnt = m_cnt + 1;
            end else begin
                m_cnt = 0;
            end
        end
    endtask

    // One clock: model check mid-cycle, DUT and model advance together.
    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input logic en, input logic trig, input logic clr);
        en_i = en; class_trig_i = trig; clr_i = clr;
        #1;
    endtask

    initial begin
        vt[0] = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 3'b000};
        vt[1] = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 3'b000};
        vt[2] = '{1'b1, 1'b1, 1'b0, 2, 1'b1, 3'b000};
        vt[3] = '{1'b1, 1'b0, 1'b0, 3, 1'b0, 3'b100};
        vt[4] = '{1'b1, 1'b1, 1'b1, 3, 1'b1, 3'b100};
        vt[5] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 3'b000};

        #1;
        chk("rst_accu", accu_cnt_o, 0);
        chk("rst_state", esc_state_o, 0);
        chk("rst_cnt", esc_cnt_o, 0);
        chk("rst_esc", esc_sig_o, 0);
        chk("rst_trig", accu_trig_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Threshold crossing on the third hit, then clear racing a hit.
        accu_thresh_i = 5'd2;
        timeout_cyc_i = 32'd0;
        phase_cyc_i   = {32'd100, 32'd100, 32'd100, 32'd100};
        for (int i = 0; i < 6; i++) begin
            set_in(vt[i].en, vt[i].trig, vt[i].clr);
            chk($sformatf("vec%0d_accu", i), accu_cnt_o, vt[i].accu);
            chk($sformatf("vec%0d_trig", i), accu_trig_o, vt[i].trig_o);
            chk($sformatf("vec%0d_state", i), esc_state_o, vt[i].st);
            tick();
        end

        // Interrupt timeout of 5 cycles.
        accu_thresh_i = 5'd31;
        timeout_cyc_i = 32'd5;
        set_in(1'b1, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("tmo_state", esc_state_o, 3'b001);
            chk("tmo_cnt", esc_cnt_o, i);
            tick();
        end
        chk("tmo_phase0", esc_state_o, 3'b100);
        set_in(1'b0, 1'b0, 1'b1);
        tick();

        // Phase walk with durations 1,2,3,4.
        accu_thresh_i = 5'd0;
        timeout_cyc_i = 32'd0;
        phase_cyc_i   = {32'd4, 32'd3, 32'd2, 32'd1};
        esc_map_i     = {2'd3, 2'd2, 2'd1, 2'd0};
        esc_en_i      = 4'b1111;
        set_in(1'b1, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j <= k; j++) begin
                chk($sformatf("walk_esc_p%0d", k), esc_sig_o, 4'b0001 << k);
                tick();
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk("term_state", esc_state_o, 3'b011);
            chk("term_esc", esc_sig_o, 0);
            chk("term_cnt", esc_cnt_o, 0);
            tick();
        end
        set_in(1'b0, 1'b0, 1'b1);
        tick();

        // Accumulator saturation, then clear together with a hit.
        accu_thresh_i = 5'd31;
        phase_cyc_i   = {32'd50, 32'd50, 32'd50, 32'd50};
        set_in(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            chk("sat_accu", accu_cnt_o, (i < ACCU_MAX) ? i : ACCU_MAX);
            tick();
        end
        set_in(1'b1, 1'b1, 1'b1);
        tick();
        chk("clrhit_accu", accu_cnt_o, 0);
        chk("clrhit_state", esc_state_o, 0);

        // Clear issued in Phase2 (optionally locked).
        accu_thresh_i = 5'd0;
        phase_cyc_i   = {32'd5, 32'd5, 32'd5, 32'd5};
        set_in(1'b1, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0);
        repeat (10) tick();
        chk("p2_state", esc_state_o, 3'b110);
`ifdef ALERT_HANDLER_CLASS_CLR_LOCK_EN
        clr_lock_i = 1'b1;
        set_in(1'b0, 1'b0, 1'b1);
        tick();
        chk("lock_state", esc_state_o, 3'b110);
        chk("lock_cnt", esc_cnt_o, 1);
        clr_lock_i = 1'b0;
`endif
        set_in(1'b0, 1'b0, 1'b1);
        tick();
        chk("clr_state", esc_state_o, 0);
        chk("clr_accu", accu_cnt_o, 0);

        // Asynchronous reset while in Phase1.
        set_in(1'b1, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0);
        repeat (5) tick();
        chk("pre_rst_state", esc_state_o, 3'b101);
        set_in(1'b1, 1'b1, 1'b0);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("arst_state", esc_state_o, 0);
        chk("arst_accu", accu_cnt_o, 0);
        chk("arst_cnt", esc_cnt_o, 0);
        chk("arst_esc", esc_sig_o, 0);
        chk("arst_trig", accu_trig_o, 0);
        m_accu = 0; m_mode = 0; m_cnt = 0;
        en_i = 1'b0; class_trig_i = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                accu_thresh_i = ACW'($urandom_range(0, 12));
                timeout_cyc_i = ECW'($urandom_range(0, 6));
                for (int k = 0; k < NP; k++)
                    phase_cyc_i[k*ECW +: ECW] = ECW'($urandom_range(0, 3));
                esc_en_i  = NS'($urandom);
                esc_map_i = (NS*PDW)'($urandom);
            end
            clr_lock_i = 1'($urandom_range(0, 1));
            set_in(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 24) == 0));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alert_handler_class_ctrl.md
ALERT_HANDLER_CLASS_CTRL -- requirements
Module: alert_handler_class_ctrl

Interface
- REQ-001 SHALL have parameter AccuCntDw, default 16, accumulator width.
- REQ-002 SHALL have parameter EscCntDw, default 32, timeout/phase counter width.
- REQ-003 SHALL have parameters N_ESC_SEV, N_PHASES and PHASE_DW, defaults 4, 4 and 2: escalation signals, phases, phase-index width.
- REQ-004 SHALL have clk_i  in  1  the single clock; all state is clocked on its rising edge.
- REQ-005 SHALL have rst_ni  in  1  reset, asynchronous and active-low.
- REQ-006 SHALL have en_i  in  1  class enable.
- REQ-007 SHALL have class_trig_i  in  1  class trigger from the upstream classification stage, one bit of its class_trig_o.
- REQ-008 SHALL have clr_i  in  1  single-cycle software clear.
- REQ-009 SHALL have accu_thresh_i  in  AccuCntDw  accumulation threshold.
- REQ-010 SHALL have timeout_cyc_i  in  EscCntDw  interrupt timeout in cycles; 0 disables the timeout.
- REQ-011 SHALL have phase_cyc_i  in  N_PHASES*EscCntDw  phase durations in cycles; phase k is at bits [k*EscCntDw +: EscCntDw].
- REQ-012 SHALL have esc_en_i  in  N_ESC_SEV  per-severity escalation enable.
- REQ-013 SHALL have esc_map_i  in  N_ESC_SEV*PHASE_DW  phase assigned to each severity.
- REQ-014 SHALL have accu_cnt_o  out  AccuCntDw  accumulator value.
- REQ-015 SHALL have accu_trig_o  out  1  threshold-crossing pulse.
- REQ-016 SHALL have esc_sig_o  out  N_ESC_SEV  escalation signals.
- REQ-017 SHALL have esc_state_o  out  3  FSM state.
- REQ-018 SHALL have esc_cnt_o  out  EscCntDw  timeout/phase counter.

Function
- REQ-019 SHALL define a hit as en_i & class_trig_i.
- REQ-020 On a hit, the accumulator SHALL increment by 1 on the next edge and saturate at all-ones; otherwise it holds.
- REQ-021 accu_trig_o SHALL equal hit & (accu_cnt_o >= accu_thresh_i), compared against the pre-increment count, combinationally.
- REQ-022 The FSM SHALL use the states Idle=000, Timeout=001, Terminal=011, Phase0=100, Phase1=101, Phase2=110, Phase3=111.
- REQ-023 In Idle: accu_trig_o SHALL go to Phase0; else a hit with timeout_cyc_i!=0 SHALL go to Timeout; else stay in Idle.
- REQ-024 In Timeout: accu_trig_o, or esc_cnt_o >= timeout_cyc_i-1, SHALL go to Phase0; else esc_cnt_o increments.
- REQ-025 Phase k SHALL last max(phase_cyc_i[k],1) cycles, then advance to Phase k+1; Phase3 SHALL advance to Terminal.
- REQ-026 Terminal SHALL hold until cleared.
- REQ-027 esc_cnt_o SHALL be 0 on every state change, SHALL saturate at all-ones, and SHALL be 0 in Idle and Terminal.
- REQ-028 esc_sig_o[s] SHALL be 1 iff esc_en_i[s] & state==Phase(esc_map_i[s]); it is a decode of the state register, with no extra latency.
- REQ-029 clr_i SHALL have priority over all other events and, on the next edge, SHALL set the accumulator to 0, esc_cnt_o to 0 and the state to Idle; a same-cycle hit is discarded.
- REQ-030 Deasserting en_i SHALL block new hits only; an escalation already in progress SHALL continue.

Reset
- REQ-031 While rst_ni=0: accu_cnt_o=0, esc_cnt_o=0, state Idle, esc_sig_o=0, accu_trig_o=0.
- REQ-032 Reset asserted mid-escalation SHALL take effect immediately, without waiting for a clock edge.

Configuration
- REQ-033 Macro ALERT_HANDLER_CLASS_CLR_LOCK_EN defined: adds port clr_lock_i (in, 1); when clr_lock_i=1 and the state is Phase0..Phase3 or Terminal, clr_i SHALL be ignored entirely.
- REQ-034 Macro ALERT_HANDLER_CLASS_CLR_LOCK_EN undefined: clr_lock_i SHALL be absent and clr_i SHALL always be effective.

Structure
- REQ-035 The state encodings, N_ESC_SEV, N_PHASES, PHASE_DW, AccuCntDw and EscCntDw SHALL reside in alert_handler_reg_pkg.
- REQ-036 The accumulator and threshold compare SHALL be the sub-module alert_handler_accu; the FSM, counter and esc_sig decode SHALL be in the top module.

Verification
- REQ-037 Bench SHALL cover: thresh=2, timeout=0, 3 consecutive hits -> accu 1,2,3; accu_trig_o on the 3rd hit; Phase0 on the next cycle.
- REQ-038 Bench SHALL cover: timeout=5, thresh=max, 1 hit -> Timeout, 5 cycles later Phase0.
- REQ-039 Bench SHALL cover: phase_cyc={1,2,3,4}, esc_map={0,1,2,3}, esc_en=1111 -> esc_sig 0001 x1, 0010 x2, 0100 x3, 1000 x4 cycles, then Terminal.
- REQ-040 Bench SHALL cover: accu at all-ones + hit -> holds all-ones; clr_i together with a hit -> accu 0, Idle.
- REQ-041 Bench SHALL cover: with CLR_LOCK_EN, clr_lock_i=1, clr_i in Phase2 -> ignored; clr_lock_i=0, clr_i -> Idle.
- REQ-042 Bench SHALL cover: rst_ni low in Phase1 -> all outputs 0 and state Idle immediately, before the next clock edge.
